// File: rtl/ps2_key_decoder_if.sv
`timescale 1ns/1ps
// PS/2 key decoder bus: raw keyboard lines in, decoded key code and frame error out.
// master drives ps2_clk/ps2_data (keyboard side) and observes key/frame_err.
// slave is the decoder side.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [1:0] key;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
// Purpose: PS/2 frame receiver + scan-code decoder for left/right arrow and spacebar.
// Latency: key/frame_err are registered, 1 clk after the stop-bit edge is seen
//          (plus 2-flop sync and FILTER_LEN debounce on ps2_clk).
// Backpressure: none; key and frame_err are single-cycle pulses, the keyboard cannot be stalled.
// Ports: clk, rst (sync, active-low), bus (ps2_key_decoder_if.slave: ps2_clk, ps2_data in; key, frame_err out).
// Optional: define PS2_PARITY_CHECK_EN to reject frames with even data+parity weight.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_key_decoder_if.slave bus
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_t;
    typedef enum logic [1:0] {D_BASE, D_EXT, D_BREAK, D_EXT_BREAK} dec_state_t;

    // ---------------- synchronizers and ps2_clk debounce ----------------
    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_filt;
    logic             clk_filt_q;
    logic [FLT_W-1:0] flt_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], bus.ps2_clk};
            data_sync  <= {data_sync[0], bus.ps2_data};
            clk_filt_q <= clk_filt;
            // Any sample matching the current filtered level restarts the run,
            // so only FILTER_LEN back-to-back differing samples flip the level.
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    logic fall;
    logic rx_bit;
    assign fall   = clk_filt_q & ~clk_filt;
    assign rx_bit = data_sync[1];

    // ---------------- receiver FSM ----------------
    rx_state_t       rx_state, rx_next;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            parity_ok;
    logic            byte_vld;
    logic            rx_err;

    assign timeout = (rx_state != R_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    // Odd parity: data plus parity bit must carry an odd number of ones.
    assign parity_ok = ^{shift, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) rx_state <= R_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (timeout) begin
            rx_next = R_IDLE;
        end else if (fall) begin
            case (rx_state)
                R_IDLE:   if (!rx_bit) rx_next = R_DATA;
                R_DATA:   if (bit_cnt == 3'd7) rx_next = R_PARITY;
                R_PARITY: rx_next = R_STOP;
                default:  rx_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_vld = 1'b0;
        rx_err   = timeout;
        if (fall && rx_state == R_STOP) begin
            byte_vld = rx_bit & parity_ok;
            rx_err   = ~(rx_bit & parity_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (rx_state == R_IDLE || fall) to_cnt <= '0;
            else                            to_cnt <= to_cnt + 1'b1;

            if (rx_state == R_IDLE) begin
                bit_cnt <= '0;
            end else if (fall && rx_state == R_DATA) begin
                shift   <= {rx_bit, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (fall && rx_state == R_PARITY) parity_bit <= rx_bit;
`endif
        end
    end

    // ---------------- scan-code decoder FSM ----------------
    dec_state_t dec_state, dec_next;
    logic [1:0] key_d;
    logic [1:0] key_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_state <= D_BASE;
            key_q     <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            dec_state <= dec_next;
            key_q     <= key_d;
            err_q     <= rx_err;
        end
    end

    always_comb begin
        dec_next = dec_state;
        // A bad frame drops any pending E0/F0 prefix.
        if (rx_err) begin
            dec_next = D_BASE;
        end else if (byte_vld) begin
            case (dec_state)
                D_BASE: begin
                    if (shift == 8'hE0)      dec_next = D_EXT;
                    else if (shift == 8'hF0) dec_next = D_BREAK;
                end
                D_EXT:   dec_next = (shift == 8'hF0) ? D_EXT_BREAK : D_BASE;
                default: dec_next = D_BASE;
            endcase
        end
    end

    always_comb begin
        key_d = 2'b00;
        if (byte_vld) begin
            if (dec_state == D_BASE && shift == 8'h29)     key_d = 2'b11;
            else if (dec_state == D_EXT && shift == 8'h6B) key_d = 2'b01;
            else if (dec_state == D_EXT && shift == 8'h74) key_d = 2'b10;
        end
    end

    assign bus.key       = key_q;
    assign bus.frame_err = err_q;
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4, the number of consecutive equal samples required to accept a ps2_clk level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65000, the clk cycles of ps2_clk idle-high that abort a partial frame.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; rst=0 resets the block at the next rising clk.
REQ-005 ps2_clk  input  1  keyboard clock, asynchronous to clk.
REQ-006 ps2_data  input  1  keyboard data, asynchronous to clk.
REQ-007 key  output  2  one-cycle key code: 00 none, 01 left arrow, 10 right arrow, 11 spacebar.
REQ-008 frame_err  output  1  one-cycle pulse on an aborted or invalid frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-010 The synchronized ps2_clk SHALL be debounced: filtered level changes only after FILTER_LEN consecutive equal samples.
REQ-011 A falling edge of the filtered ps2_clk SHALL sample the synchronized ps2_data.
REQ-012 Receiver FSM states SHALL be R_IDLE, R_DATA, R_PARITY, R_STOP.
REQ-013 R_IDLE: a sampled 0 (start bit) SHALL go to R_DATA; a sampled 1 SHALL stay in R_IDLE with no error.
REQ-014 R_DATA: SHALL shift 8 bits LSB first through a 3-bit counter, then go to R_PARITY.
REQ-015 R_PARITY: SHALL store the sampled bit and go to R_STOP.
REQ-016 R_STOP: sampled 1 SHALL deliver the byte to the decoder for one cycle; sampled 0 SHALL pulse frame_err and discard the byte; both SHALL go to R_IDLE.
REQ-017 Outside R_IDLE, TIMEOUT_CYCLES clk cycles with no filtered falling edge SHALL return to R_IDLE and pulse frame_err once; the counter SHALL clear on every falling edge.
REQ-018 Decoder FSM states SHALL be D_BASE, D_EXT, D_BREAK, D_EXT_BREAK.
REQ-019 D_BASE: E0 SHALL go to D_EXT; F0 SHALL go to D_BREAK; 29 SHALL emit key=11; any other byte SHALL be ignored.
REQ-020 D_EXT: F0 SHALL go to D_EXT_BREAK; 6B SHALL emit 01; 74 SHALL emit 10; any other byte SHALL emit nothing. All cases except F0 SHALL return to D_BASE.
REQ-021 D_BREAK and D_EXT_BREAK: the next byte SHALL be consumed with no emission and SHALL return to D_BASE.
REQ-022 key SHALL be registered and SHALL be non-zero for exactly one clk cycle, 1 cycle after the final byte is delivered; otherwise 00.
REQ-023 Typematic repeats SHALL be decoded as new make codes and SHALL produce one pulse per repeat.
REQ-024 frame_err SHALL reset the decoder FSM to D_BASE in the same cycle, so a prefix is never applied across a bad frame.
REQ-025 frame_err and a key pulse SHALL never be asserted in the same cycle.

Reset
REQ-026 While rst=0, key SHALL be 00, frame_err 0, the receiver in R_IDLE, the decoder in D_BASE, and the shift register, bit counter, timeout counter and filter cleared; the filtered ps2_clk SHALL reset to 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; a clean frame after release SHALL decode normally.

Configuration
REQ-028 With macro PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit have even weight SHALL be discarded in R_STOP with a frame_err pulse.
REQ-029 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and no parity logic SHALL be synthesized.

Verification
REQ-030 Frame 29 (parity 0, stop 1) at 12.5 kHz PS/2 clock -> exactly one cycle key=11; frame_err stays 0.
REQ-031 Frames E0 then 6B -> one pulse key=01; frames E0, F0, 6B -> no pulse, decoder ends in D_BASE.
REQ-032 Frames F0 then 29 -> no pulse; a following frame 29 -> one pulse key=11.
REQ-033 Frame 74 sent with parity 0, PS2_PARITY_CHECK_EN defined -> frame_err pulse, no key; macro undefined -> no pulse and no error (74 alone is not extended).
REQ-034 Frame E0, then a frame cut after 4 data bits held idle TIMEOUT_CYCLES -> one frame_err pulse; a following frame 6B yields no key because the prefix was cleared.
REQ-035 1-cycle glitches on ps2_clk, plus rst=0 pulsed mid-frame -> no spurious edges; a following full frame 29 -> key=11 once.
